uart_avalon_bridge: RTL and testbench
=====================================

Name: uart_avalon_bridge

Overview:
- UART-side bus initiator: parses command frames from the UartRx byte stream and issues single-word Avalon reads/writes as bus master.
- Returns responses through UartTx.
- Counterpart to the UART bus interface: it drives the bus from a host link instead of responding to the bus.
- Sits between the UartRx/UartTx pair and the SOC data-bus arbiter; serves debug and boot-load access.

Parameters:
- READ_LATENCY, 1, cycles from accepted read (Read high, WaitRequest low) to valid i_AV_ReadData; range 1-4.
- TIMEOUT_CLKS, 1000000, max idle clocks between bytes of one frame before the parser aborts; 0 disables.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_RxDataValid  in  1  one-cycle strobe, received byte valid
- i_RxData  in  8  received byte
- o_TxEn  out  1  one-cycle strobe, start sending o_TxData
- o_TxData  out  8  byte to transmit, held stable while TX busy
- i_TxIdle  in  1  UartTx idle
- o_AV_Address  out  32  byte address, bits[1:0] forced 0
- o_AV_ByteEn  out  4  always 4'hF
- o_AV_Read  out  1  read request
- o_AV_Write  out  1  write request
- o_AV_WriteData  out  32  write data
- i_AV_ReadData  in  32  read data
- i_AV_WaitRequest  in  1  slave stall
- o_Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0 except o_AV_ByteEn = 4'hF; FSM in IDLE; shift registers cleared.
- Frame formats:
  - Write: 0x57 'W', A0..A3, D0..D3. All multi-byte fields little-endian.
  - Read: 0x52 'R', A0..A3.
- FSM states: IDLE, ADDR, DATA, BUS, RDWAIT, RESP.
- IDLE, on byte:
  - 0x57 or 0x52: latch op, go to ADDR.
  - Any other byte: load NAK 0x15 into response buffer (1 byte), go to RESP.
- ADDR: shift 4 bytes into the address (A0 lands in [7:0]). After the 4th byte: write goes to DATA, read goes to BUS.
- DATA: shift 4 bytes into o_AV_WriteData, then go to BUS.
- BUS:
  - Assert o_AV_Write or o_AV_Read the cycle after entry.
  - Hold address, data and strobe constant while i_AV_WaitRequest = 1.
  - The strobe drops in the cycle after the first sample with WaitRequest = 0; exactly one transfer per frame.
  - Write done: load ACK 0x06, go to RESP.
  - Read accepted: go to RDWAIT.
- RDWAIT: count READ_LATENCY cycles, capture i_AV_ReadData, load 4 bytes (LSB first), go to RESP.
- RESP:
  - Pulse o_TxEn when i_TxIdle = 1 and o_TxEn was not high the previous cycle.
  - After each pulse, ignore i_TxIdle for 1 cycle (TX idle-drop latency).
  - After the last byte is handed off, return to IDLE.
- Rx bytes arriving during BUS, RDWAIT or RESP are dropped; no queuing.
- Timeout: counter cleared on every i_RxDataValid. In ADDR or DATA, reaching TIMEOUT_CLKS returns the FSM to IDLE silently, with no bus cycle and no response.
- Timeout is not applied in BUS: a stalled slave holds the bridge indefinitely.
- Reset mid-bus-cycle: strobes drop the next edge; the transaction is abandoned.
- Addresses are not range-checked; bits[1:0] are ignored.

Optional Feature:
- Macro: UART_BRIDGE_CHECKSUM_EN.
- Defined:
  - A CHK state follows the last address/data byte.
  - One extra byte is expected: XOR of all preceding frame bytes including the command.
  - Mismatch: no bus cycle, respond NAK 0x15.
  - Read responses append a 5th byte, the XOR of the 4 data bytes.
  - Write ACK remains the single byte 0x06.
- Undefined: CHK state and checksum logic absent; frames as above.

Test Plan:
- Write frame 57 10 00 00 40 EF BE AD DE, WaitRequest low -> one o_AV_Write cycle, Address 0x40000010, WriteData 0xDEADBEEF, ByteEn F; TX sends 06.
- Read frame 52 04 00 00 40, slave returns 0x12345678 with READ_LATENCY=1 -> one o_AV_Read cycle; TX sends 78 56 34 12 in order, each o_TxEn only when i_TxIdle high.
- Write with WaitRequest held high 5 cycles -> Write, Address and WriteData stable for 6 cycles; exactly one accepted transfer; single 06.
- Byte 0x41 in IDLE -> TX sends 15, no bus activity; the following valid read frame is processed normally.
- TIMEOUT_CLKS=100: send 52 04 00, then stall 101 clocks -> FSM returns to IDLE, no Read, no TX; a new full frame then succeeds.
- UART_BRIDGE_CHECKSUM_EN: frame 52 00 00 00 00 with checksum 0x52 -> read issued, 5 response bytes. Same frame with checksum 0x53 -> TX 15, no read.

Source files
------------

// File: rtl/uart_avalon_bridge.sv
// -----------------------------------------------------------------------------
// uart_avalon_bridge
//
// Host-link bus initiator. Parses command frames arriving on the UART receive
// byte stream and issues one single-word Avalon-MM read or write per frame.
// The result is returned as bytes through the UART transmitter.
//
// Frame formats (multi-byte fields little-endian):
//   write : 0x57 A0 A1 A2 A3 D0 D1 D2 D3   -> response 0x06
//   read  : 0x52 A0 A1 A2 A3               -> response RD0 RD1 RD2 RD3
//   unknown command byte                   -> response 0x15
//
// Optional feature macro: UART_BRIDGE_CHECKSUM_EN
//   When defined, each frame carries one trailing byte equal to the XOR of all
//   preceding frame bytes (command included). A bad checksum suppresses the bus
//   cycle and returns 0x15. Read responses gain a fifth byte, the XOR of the
//   four data bytes. The write ACK stays a single 0x06.
//
// Parameters:
//   READ_LATENCY  cycles from accepted read to valid i_AV_ReadData (1..4)
//   TIMEOUT_CLKS  idle clocks between bytes of a frame before abort (0 = off)
//
// Ports:
//   i_Clk, i_Reset                clock, synchronous active-high reset
//   i_RxDataValid, i_RxData       received byte strobe and data
//   o_TxEn, o_TxData, i_TxIdle    transmit start strobe, byte, transmitter idle
//   o_AV_*                        Avalon-MM master (address, byteenable,
//                                 read, write, writedata)
//   i_AV_ReadData, i_AV_WaitRequest  Avalon-MM read data and slave stall
//   o_Busy                        high whenever the parser is not idle
// -----------------------------------------------------------------------------
module uart_avalon_bridge #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_RxDataValid,
  input  logic [7:0]  i_RxData,
  output logic        o_TxEn,
  output logic [7:0]  o_TxData,
  input  logic        i_TxIdle,
  output logic [31:0] o_AV_Address,
  output logic [3:0]  o_AV_ByteEn,
  output logic        o_AV_Read,
  output logic        o_AV_Write,
  output logic [31:0] o_AV_WriteData,
  input  logic [31:0] i_AV_ReadData,
  input  logic        i_AV_WaitRequest,
  output logic        o_Busy
);

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RSP_ACK   = 8'h06;
  localparam logic [7:0]  RSP_NAK   = 8'h15;
  localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CLKS);
  localparam logic [2:0]  LAT_INIT  = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_BUS    = 3'd3,
    ST_RDWAIT = 3'd4,
    ST_RESP   = 3'd5
`ifdef UART_BRIDGE_CHECKSUM_EN
    ,
    ST_CHK    = 3'd6
`endif
  } stateT;

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam logic [2:0] READ_RSP_LEN    = 3'd5;
  localparam stateT      AFTER_FIELDS_ST = ST_CHK;

  // XOR of the four bytes of a word; used for the read-response check byte.
  function automatic logic [7:0] xorBytes(input logic [31:0] word);
    xorBytes = word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
  endfunction
`else
  localparam logic [2:0] READ_RSP_LEN    = 3'd4;
  localparam stateT      AFTER_FIELDS_ST = ST_BUS;
`endif

  stateT       state_r;
  logic        isWrite_r;
  logic [1:0]  byteCnt_r;
  logic [23:0] addrSh_r;      // A0..A2 while the address is being assembled
  logic        busIssued_r;
  logic [2:0]  latCnt_r;
  logic [39:0] rspBuf_r;      // next byte to send sits in [7:0]
  logic [2:0]  rspLeft_r;
  logic        txHold_r;      // masks i_TxIdle the cycle after a strobe
  logic [31:0] toCnt_r;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]  chk_r;
`endif

  logic        frameState_s;
  logic        toExpire_s;

  // Decode frame-collection states and detect an expired inter-byte gap.
  always_comb begin
    frameState_s = 1'b0;
    toExpire_s   = 1'b0;
    case (state_r)
      ST_ADDR, ST_DATA: frameState_s = 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
      ST_CHK:           frameState_s = 1'b1;
`endif
      default:          frameState_s = 1'b0;
    endcase
    // A byte arriving in the same cycle as expiry wins over the abort.
    if ((TO_LIMIT != 32'd0) && frameState_s && !i_RxDataValid &&
        (toCnt_r == (TO_LIMIT - 32'd1))) begin
      toExpire_s = 1'b1;
    end else begin
      toExpire_s = 1'b0;
    end
  end

  // Inter-byte idle counter; only runs while a frame is being collected.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      toCnt_r <= 32'd0;
    end else if (i_RxDataValid || !frameState_s) begin
      toCnt_r <= 32'd0;
    end else if (toCnt_r != 32'hFFFF_FFFF) begin
      toCnt_r <= toCnt_r + 32'd1;
    end else begin
      toCnt_r <= toCnt_r;
    end
  end

  // Frame parser, bus master sequencing and response transmit pacing.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r        <= ST_IDLE;
      isWrite_r      <= 1'b0;
      byteCnt_r      <= 2'd0;
      addrSh_r       <= 24'd0;
      busIssued_r    <= 1'b0;
      latCnt_r       <= 3'd0;
      rspBuf_r       <= 40'd0;
      rspLeft_r      <= 3'd0;
      txHold_r       <= 1'b0;
      o_TxEn         <= 1'b0;
      o_TxData       <= 8'h00;
      o_AV_Address   <= 32'd0;
      o_AV_ByteEn    <= 4'hF;
      o_AV_Read      <= 1'b0;
      o_AV_Write     <= 1'b0;
      o_AV_WriteData <= 32'd0;
      o_Busy         <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      chk_r          <= 8'h00;
`endif
    end else begin
      o_TxEn      <= 1'b0;
      txHold_r    <= o_TxEn;
      o_AV_ByteEn <= 4'hF;
      case (state_r)
        ST_IDLE: begin
          if (i_RxDataValid) begin
            o_Busy    <= 1'b1;
            byteCnt_r <= 2'd0;
            if ((i_RxData == CMD_WRITE) || (i_RxData == CMD_READ)) begin
              isWrite_r <= (i_RxData == CMD_WRITE);
              state_r   <= ST_ADDR;
`ifdef UART_BRIDGE_CHECKSUM_EN
              chk_r     <= i_RxData;
`endif
            end else begin
              rspBuf_r  <= {32'd0, RSP_NAK};
              rspLeft_r <= 3'd1;
              state_r   <= ST_RESP;
            end
          end
        end

        ST_ADDR: begin
          if (toExpire_s) begin
            state_r <= ST_IDLE;
            o_Busy  <= 1'b0;
          end else if (i_RxDataValid) begin
            addrSh_r  <= {i_RxData, addrSh_r[23:8]};
            byteCnt_r <= byteCnt_r + 2'd1;
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk_r     <= chk_r ^ i_RxData;
`endif
            if (byteCnt_r == 2'd3) begin
              // Word-aligned: the two low address bits are discarded.
              o_AV_Address <= {i_RxData, addrSh_r} & 32'hFFFF_FFFC;
              if (isWrite_r) begin
                state_r <= ST_DATA;
              end else begin
                state_r <= AFTER_FIELDS_ST;
              end
            end
          end
        end

        ST_DATA: begin
          if (toExpire_s) begin
            state_r <= ST_IDLE;
            o_Busy  <= 1'b0;
          end else if (i_RxDataValid) begin
            o_AV_WriteData <= {i_RxData, o_AV_WriteData[31:8]};
            byteCnt_r      <= byteCnt_r + 2'd1;
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk_r          <= chk_r ^ i_RxData;
`endif
            if (byteCnt_r == 2'd3) begin
              state_r <= AFTER_FIELDS_ST;
            end
          end
        end

`ifdef UART_BRIDGE_CHECKSUM_EN
        ST_CHK: begin
          if (toExpire_s) begin
            state_r <= ST_IDLE;
            o_Busy  <= 1'b0;
          end else if (i_RxDataValid) begin
            if (i_RxData == chk_r) begin
              state_r <= ST_BUS;
            end else begin
              rspBuf_r  <= {32'd0, RSP_NAK};
              rspLeft_r <= 3'd1;
              state_r   <= ST_RESP;
            end
          end
        end
`endif

        ST_BUS: begin
          if (!busIssued_r) begin
            busIssued_r <= 1'b1;
            o_AV_Write  <= isWrite_r;
            o_AV_Read   <= !isWrite_r;
          end else if (!i_AV_WaitRequest) begin
            // Transfer accepted this edge: drop the strobe, exactly one per frame.
            busIssued_r <= 1'b0;
            o_AV_Write  <= 1'b0;
            o_AV_Read   <= 1'b0;
            if (isWrite_r) begin
              rspBuf_r  <= {32'd0, RSP_ACK};
              rspLeft_r <= 3'd1;
              state_r   <= ST_RESP;
            end else begin
              latCnt_r <= LAT_INIT;
              state_r  <= ST_RDWAIT;
            end
          end else begin
            // Slave stalled: address, data and strobe stay as they are.
            busIssued_r <= busIssued_r;
          end
        end

        ST_RDWAIT: begin
          if (latCnt_r == 3'd0) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            rspBuf_r <= {xorBytes(i_AV_ReadData), i_AV_ReadData};
`else
            rspBuf_r <= {8'h00, i_AV_ReadData};
`endif
            rspLeft_r <= READ_RSP_LEN;
            state_r   <= ST_RESP;
          end else begin
            latCnt_r <= latCnt_r - 3'd1;
          end
        end

        ST_RESP: begin
          // The transmitter needs a cycle to drop i_TxIdle after a strobe.
          if (i_TxIdle && !o_TxEn && !txHold_r) begin
            o_TxEn    <= 1'b1;
            o_TxData  <= rspBuf_r[7:0];
            rspBuf_r  <= {8'h00, rspBuf_r[39:8]};
            rspLeft_r <= rspLeft_r - 3'd1;
            if (rspLeft_r == 3'd1) begin
              state_r <= ST_IDLE;
              o_Busy  <= 1'b0;
            end
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          o_Busy      <= 1'b0;
          o_AV_Read   <= 1'b0;
          o_AV_Write  <= 1'b0;
          busIssued_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_avalon_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_avalon_bridge
//
// Directed bench for uart_avalon_bridge. Drives command frames byte by byte,
// models an Avalon slave (programmable stall, fixed read latency) and a UART
// transmitter (busy for a number of cycles after each start strobe), and
// compares bus transfers and transmitted bytes with hand-computed values.
// Honours UART_BRIDGE_CHECKSUM_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_uart_avalon_bridge;

  localparam int RD_LAT  = 1;
  localparam int TO_CLKS = 100;
`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam int RD_RSP = 5;
`else
  localparam int RD_RSP = 4;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_RxDataValid = 1'b0;
  logic [7:0]  i_RxData = 8'h00;
  logic        o_TxEn;
  logic [7:0]  o_TxData;
  logic        i_TxIdle = 1'b1;
  logic [31:0] o_AV_Address;
  logic [3:0]  o_AV_ByteEn;
  logic        o_AV_Read;
  logic        o_AV_Write;
  logic [31:0] o_AV_WriteData;
  logic [31:0] i_AV_ReadData = 32'hBAD0_BAD0;
  logic        i_AV_WaitRequest = 1'b0;
  logic        o_Busy;

  always #5 i_Clk = ~i_Clk;

  uart_avalon_bridge #(
    .READ_LATENCY(RD_LAT),
    .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .i_RxDataValid(i_RxDataValid),
    .i_RxData(i_RxData),
    .o_TxEn(o_TxEn),
    .o_TxData(o_TxData),
    .i_TxIdle(i_TxIdle),
    .o_AV_Address(o_AV_Address),
    .o_AV_ByteEn(o_AV_ByteEn),
    .o_AV_Read(o_AV_Read),
    .o_AV_Write(o_AV_Write),
    .o_AV_WriteData(o_AV_WriteData),
    .i_AV_ReadData(i_AV_ReadData),
    .i_AV_WaitRequest(i_AV_WaitRequest),
    .o_Busy(o_Busy)
  );

  int compared = 0;
  int mismatched = 0;

  // Test-controlled slave behaviour
  int          stallReq = 0;
  logic [31:0] rdValue = 32'd0;

  // Monitor-owned observations (monotonic counters)
  int          stallCnt = 0;
  int          rdPend = 0;
  int          wrCycles = 0, rdCycles = 0, wrAcc = 0, rdAcc = 0;
  int          stableErr = 0, byteEnErr = 0, bothErr = 0, txRuleErr = 0;
  int          txBusyLeft = 0;
  logic [31:0] accAddr = 32'd0, accData = 32'd0;
  logic        prevStrobe = 1'b0, prevTxEn = 1'b0, idleAtEdge = 1'b1;
  logic [31:0] prevAddr = 32'd0, prevData = 32'd0;
  logic [7:0]  txQ[$];

  // Baselines taken by the test sequence
  int bWrCyc, bRdCyc, bWrAcc, bRdAcc, bStable, bTx;

  task automatic checkResult(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // What the DUT saw on i_TxIdle at the edge that raised o_TxEn.
  always @(posedge i_Clk) idleAtEdge <= i_TxIdle;

  // Avalon slave and UART transmitter models.
  always @(negedge i_Clk) begin
    if (rdPend > 0) begin
      rdPend = rdPend - 1;
      i_AV_ReadData = (rdPend == 0) ? rdValue : 32'hBAD0_BAD0;
    end else begin
      i_AV_ReadData = 32'hBAD0_BAD0;
    end

    if (o_AV_Write || o_AV_Read) begin
      if (o_AV_Write && o_AV_Read) bothErr++;
      if (o_AV_Write) wrCycles++; else rdCycles++;
      if (o_AV_ByteEn !== 4'hF) byteEnErr++;
      if (prevStrobe && ((o_AV_Address !== prevAddr) || (o_AV_WriteData !== prevData))) stableErr++;
      i_AV_WaitRequest = (stallCnt < stallReq);
      stallCnt++;
      if (!i_AV_WaitRequest) begin
        accAddr = o_AV_Address;
        if (o_AV_Write) begin
          wrAcc++;
          accData = o_AV_WriteData;
        end else begin
          rdAcc++;
          rdPend = RD_LAT;
        end
      end
    end else begin
      i_AV_WaitRequest = 1'b0;
      stallCnt = 0;
    end
    prevStrobe = o_AV_Write || o_AV_Read;
    prevAddr   = o_AV_Address;
    prevData   = o_AV_WriteData;

    if (o_TxEn) begin
      txQ.push_back(o_TxData);
      if (!idleAtEdge || prevTxEn) txRuleErr++;
      i_TxIdle = 1'b0;
      txBusyLeft = 12;
    end else if (txBusyLeft > 0) begin
      txBusyLeft--;
      if (txBusyLeft == 0) i_TxIdle = 1'b1;
    end
    prevTxEn = o_TxEn;
  end

  task automatic takeBase();
    bWrCyc  = wrCycles;
    bRdCyc  = rdCycles;
    bWrAcc  = wrAcc;
    bRdAcc  = rdAcc;
    bStable = stableErr;
    bTx     = txQ.size();
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge i_Clk);
    i_RxDataValid = 1'b1;
    i_RxData = b;
    @(negedge i_Clk);
    i_RxDataValid = 1'b0;
  endtask

  // Bytes are taken from the top of 'frame'; a checksum byte is appended
  // when the checksum build is active (inverted LSB when badChk is set).
  task automatic sendFrame(input logic [71:0] frame, input int nBytes, input logic badChk);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < nBytes; i++) begin
      b = frame[71 - 8*i -: 8];
      x = x ^ b;
      sendByte(b);
      repeat (3) @(negedge i_Clk);
    end
    if (badChk) x = x ^ 8'h01;
`ifdef UART_BRIDGE_CHECKSUM_EN
    sendByte(x);
`endif
  endtask

  task automatic waitDone(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_Clk);
      if (!o_Busy && !o_TxEn && (txBusyLeft == 0) && (rdPend == 0)) begin
        done = 1'b1;
        break;
      end
    end
    checkResult({tag, "_done"}, {63'd0, done}, 64'd1);
    repeat (2) @(negedge i_Clk);
    #1;
  endtask

  task automatic checkTx(input string tag, input logic [39:0] exp, input int n);
    checkResult({tag, "_txlen"}, 64'(txQ.size() - bTx), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (bTx + i < txQ.size())
        checkResult($sformatf("%s_tx%0d", tag, i), {56'd0, txQ[bTx + i]}, {56'd0, exp[39 - 8*i -: 8]});
      else
        checkResult($sformatf("%s_tx%0d", tag, i), 64'hFFFF_FFFF_FFFF_FFFF, {56'd0, exp[39 - 8*i -: 8]});
    end
  endtask

  initial begin
    logic seen;

    // Reset values
    repeat (3) @(negedge i_Clk);
    checkResult("rst_txen",  {63'd0, o_TxEn}, 64'd0);
    checkResult("rst_txdata", {56'd0, o_TxData}, 64'd0);
    checkResult("rst_addr",  {32'd0, o_AV_Address}, 64'd0);
    checkResult("rst_byteen", {60'd0, o_AV_ByteEn}, 64'hF);
    checkResult("rst_read",  {63'd0, o_AV_Read}, 64'd0);
    checkResult("rst_write", {63'd0, o_AV_Write}, 64'd0);
    checkResult("rst_wdata", {32'd0, o_AV_WriteData}, 64'd0);
    checkResult("rst_busy",  {63'd0, o_Busy}, 64'd0);
    i_Reset = 1'b0;
    repeat (2) @(negedge i_Clk);

    // Plain write
    takeBase();
    sendFrame(72'h57_10_00_00_40_EF_BE_AD_DE, 9, 1'b0);
    waitDone("wr");
    checkResult("wr_acc",  64'(wrAcc - bWrAcc), 64'd1);
    checkResult("wr_cyc",  64'(wrCycles - bWrCyc), 64'd1);
    checkResult("wr_addr", {32'd0, accAddr}, 64'h4000_0010);
    checkResult("wr_data", {32'd0, accData}, 64'hDEAD_BEEF);
    checkTx("wr", 40'h06_00_00_00_00, 1);

    // Plain read
    takeBase();
    rdValue = 32'h1234_5678;
    sendFrame(72'h52_04_00_00_40_00_00_00_00, 5, 1'b0);
    waitDone("rd");
    checkResult("rd_acc",  64'(rdAcc - bRdAcc), 64'd1);
    checkResult("rd_cyc",  64'(rdCycles - bRdCyc), 64'd1);
    checkResult("rd_addr", {32'd0, accAddr}, 64'h4000_0004);
    checkTx("rd", 40'h78_56_34_12_08, RD_RSP);

    // Write stalled by the slave for 5 cycles
    takeBase();
    stallReq = 5;
    sendFrame(72'h57_00_01_00_00_44_33_22_11, 9, 1'b0);
    waitDone("stall");
    stallReq = 0;
    checkResult("stall_cyc", 64'(wrCycles - bWrCyc), 64'd6);
    checkResult("stall_acc", 64'(wrAcc - bWrAcc), 64'd1);
    checkResult("stall_stable", 64'(stableErr - bStable), 64'd0);
    checkResult("stall_addr", {32'd0, accAddr}, 64'h0000_0100);
    checkResult("stall_data", {32'd0, accData}, 64'h1122_3344);
    checkTx("stall", 40'h06_00_00_00_00, 1);

    // Unknown command byte, then a read with unaligned address
    takeBase();
    sendByte(8'h41);
    waitDone("nak");
    checkResult("nak_bus", 64'((wrCycles - bWrCyc) + (rdCycles - bRdCyc)), 64'd0);
    checkTx("nak", 40'h15_00_00_00_00, 1);
    takeBase();
    rdValue = 32'hCAFE_F00D;
    sendFrame(72'h52_0B_00_00_00_00_00_00_00, 5, 1'b0);
    waitDone("rd2");
    checkResult("rd2_acc",  64'(rdAcc - bRdAcc), 64'd1);
    checkResult("rd2_addr", {32'd0, accAddr}, 64'h0000_0008);
    checkTx("rd2", 40'h0D_F0_FE_CA_C9, RD_RSP);

    // Inter-byte timeout after a partial frame
    takeBase();
    sendByte(8'h52);
    repeat (3) @(negedge i_Clk);
    sendByte(8'h04);
    repeat (3) @(negedge i_Clk);
    sendByte(8'h00);
    repeat (90) @(negedge i_Clk);
    checkResult("to_busy_before", {63'd0, o_Busy}, 64'd1);
    repeat (11) @(negedge i_Clk);
    checkResult("to_busy_after", {63'd0, o_Busy}, 64'd0);
    checkResult("to_noread", 64'(rdCycles - bRdCyc), 64'd0);
    checkResult("to_notx", 64'(txQ.size() - bTx), 64'd0);
    takeBase();
    rdValue = 32'h0102_0304;
    sendFrame(72'h52_10_00_00_00_00_00_00_00, 5, 1'b0);
    waitDone("rd3");
    checkResult("rd3_addr", {32'd0, accAddr}, 64'h0000_0010);
    checkTx("rd3", 40'h04_03_02_01_04, RD_RSP);

    // Reset while the slave stalls a write
    takeBase();
    stallReq = 1000;
    sendFrame(72'h57_20_00_00_00_01_00_00_00, 9, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_AV_Write) begin
        seen = 1'b1;
        break;
      end
      @(negedge i_Clk);
    end
    checkResult("rstbus_seen", {63'd0, seen}, 64'd1);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    checkResult("rstbus_write", {63'd0, o_AV_Write}, 64'd0);
    checkResult("rstbus_busy",  {63'd0, o_Busy}, 64'd0);
    i_Reset = 1'b0;
    stallReq = 0;
    repeat (20) @(negedge i_Clk);
    checkResult("rstbus_noacc", 64'(wrAcc - bWrAcc), 64'd0);
    checkResult("rstbus_notx",  64'(txQ.size() - bTx), 64'd0);

`ifdef UART_BRIDGE_CHECKSUM_EN
    // Good and bad checksum on the same read frame
    takeBase();
    rdValue = 32'hA1B2_C3D4;
    sendFrame(72'h52_00_00_00_00_00_00_00_00, 5, 1'b0);
    waitDone("chk_ok");
    checkResult("chk_ok_acc", 64'(rdAcc - bRdAcc), 64'd1);
    checkTx("chk_ok", 40'hD4_C3_B2_A1_04, 5);
    takeBase();
    sendFrame(72'h52_00_00_00_00_00_00_00_00, 5, 1'b1);
    waitDone("chk_bad");
    checkResult("chk_bad_noread", 64'(rdCycles - bRdCyc), 64'd0);
    checkTx("chk_bad", 40'h15_00_00_00_00, 1);
`endif

    // Global protocol rules over the whole run
    checkResult("byteen_rule", 64'(byteEnErr), 64'd0);
    checkResult("both_strobes", 64'(bothErr), 64'd0);
    checkResult("tx_rule", 64'(txRuleErr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Overall watchdog in case a wait is never satisfied.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
